play_engine: RTL

PLAY_ENGINE -- requirements
Module: play_engine

---
 rtl/play_if.sv | 35 +++
 rtl/play_engine.sv | 139 +++++++++++++
 2 files changed

// File: rtl/play_if.sv
// Control, memory and codec-side signals of the chunk playback engine.
// The controller/bench drives through master; the engine uses slave.
interface play_if;
  logic        i_start;
  logic [22:0] i_select0;
  logic [22:0] i_select1;
  logic        i_record;
  logic [1:0]  i_speed;
  logic        i_stop;
  logic        o_done;
  logic        o_busy;
  logic [22:0] o_mem_addr;
  logic        o_mem_rd;
  logic [15:0] i_mem_rdata;
  logic        i_mem_rvalid;
  logic        o_mem_wr;
  logic [15:0] o_mem_wdata;
  logic        i_sample_req;
  logic [15:0] o_sample;
  logic        o_sample_valid;

  modport master (
    output i_start, i_select0, i_select1, i_record, i_speed, i_stop,
    output i_mem_rdata, i_mem_rvalid, i_sample_req,
    input  o_done, o_busy, o_mem_addr, o_mem_rd, o_mem_wr, o_mem_wdata,
    input  o_sample, o_sample_valid
  );

  modport slave (
    input  i_start, i_select0, i_select1, i_record, i_speed, i_stop,
    input  i_mem_rdata, i_mem_rvalid, i_sample_req,
    output o_done, o_busy, o_mem_addr, o_mem_rd, o_mem_wr, o_mem_wdata,
    output o_sample, o_sample_valid
  );
endinterface

// File: rtl/play_engine.sv
// Plays one chunk of 16-bit samples from memory at 1x/2x/0.5x speed, optionally
// copying each fetched sample to a record chunk. All outputs are registered.
module play_engine #(
  parameter int unsigned CHUNK_WORDS = 1048576
) (
  input logic   i_clk,
  input logic   i_rst,
  play_if.slave bus
);
  localparam int DATA_W = 16;
  localparam logic [23:0] CHUNK = 24'(CHUNK_WORDS);

  typedef enum logic [2:0] {IDLE, FETCH, WAITRD, WRITE, READY, DONE, RELEASE} state_t;

  state_t              state;
  logic [22:0]         base0;
  logic [22:0]         base1;
  logic                rec;
  logic [1:0]          speed;
  logic [23:0]         offset;
  logic                half;
  logic                stop_flag;
  logic [DATA_W-1:0]   buffer;

  logic                stop_now;
  logic                advance;
  logic [23:0]         next_off;

  // Offset is one bit wider than an address so the end-of-chunk compare never wraps.
  always_comb begin
    stop_now = stop_flag | bus.i_stop;
    advance  = !(speed == 2'd2 && !half);
    next_off = offset + ((speed == 2'd1) ? 24'd2 : 24'd1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state              <= IDLE;
      base0              <= '0;
      base1              <= '0;
      rec                <= 1'b0;
      speed              <= 2'd0;
      offset             <= '0;
      half               <= 1'b0;
      stop_flag          <= 1'b0;
      buffer             <= '0;
      bus.o_done         <= 1'b0;
      bus.o_busy         <= 1'b0;
      bus.o_mem_addr     <= '0;
      bus.o_mem_rd       <= 1'b0;
      bus.o_mem_wr       <= 1'b0;
      bus.o_mem_wdata    <= '0;
      bus.o_sample       <= '0;
      bus.o_sample_valid <= 1'b0;
    end else begin
      bus.o_mem_rd       <= 1'b0;
      bus.o_mem_wr       <= 1'b0;
      bus.o_done         <= 1'b0;
      bus.o_sample_valid <= 1'b0;
      if (state != IDLE && bus.i_stop) stop_flag <= 1'b1;

      // Strobes are set on the transition into their state so they coincide with it.
      case (state)
        IDLE: if (bus.i_start) begin
          base0          <= bus.i_select0;
          base1          <= bus.i_select1;
          rec            <= bus.i_record;
          speed          <= bus.i_speed;
          offset         <= '0;
          half           <= 1'b0;
          stop_flag      <= 1'b0;
          bus.o_busy     <= 1'b1;
          bus.o_mem_rd   <= 1'b1;
          bus.o_mem_addr <= bus.i_select0;
          state          <= FETCH;
        end
        FETCH: state <= WAITRD;
        WAITRD: if (bus.i_mem_rvalid) begin
          if (stop_now) begin
            bus.o_done <= 1'b1;
            state      <= DONE;
          end else begin
            buffer <= bus.i_mem_rdata;
            if (rec) begin
              bus.o_mem_wr    <= 1'b1;
              bus.o_mem_addr  <= base1 + offset[22:0];
              bus.o_mem_wdata <= bus.i_mem_rdata;
              state           <= WRITE;
            end else begin
              state <= READY;
            end
          end
        end
        WRITE: begin
          if (stop_now) begin
            bus.o_done <= 1'b1;
            state      <= DONE;
          end else begin
            state <= READY;
          end
        end
        READY: begin
          if (bus.i_sample_req) begin
            bus.o_sample       <= buffer;
            bus.o_sample_valid <= 1'b1;
            if (!advance) begin
              // First half of a 0.5x pair: replay the same buffer on the next tick.
              half <= 1'b1;
              if (stop_now) begin
                bus.o_done <= 1'b1;
                state      <= DONE;
              end
            end else begin
              half   <= 1'b0;
              offset <= next_off;
              if (next_off >= CHUNK || stop_now) begin
                bus.o_done <= 1'b1;
                state      <= DONE;
              end else begin
                bus.o_mem_rd   <= 1'b1;
                bus.o_mem_addr <= base0 + next_off[22:0];
                state          <= FETCH;
              end
            end
          end else if (stop_now) begin
            bus.o_done <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: state <= RELEASE;
        RELEASE: if (!bus.i_start) begin
          bus.o_busy <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
